// File: rtl/vga_sync_decoder_if.sv
// Sync input pair plus recovered position/lock outputs of the VGA sync decoder.
// The decoder side takes the slave modport; the sync source / observer takes master.
interface vga_sync_decoder_if;
  logic       i_hsync;
  logic       i_vsync;
  logic       o_hsync;
  logic       o_vsync;
  logic [9:0] o_col;
  logic [9:0] o_row;
  logic       o_active;
  logic       o_frame_start;
  logic       o_locked;
  logic [7:0] o_err_count;

  modport slave (
    input  i_hsync, i_vsync,
    output o_hsync, o_vsync, o_col, o_row, o_active,
           o_frame_start, o_locked, o_err_count
  );

  modport master (
    output i_hsync, i_vsync,
    input  o_hsync, o_vsync, o_col, o_row, o_active,
           o_frame_start, o_locked, o_err_count
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds column/row from hsync/vsync,
// validates line and frame lengths and tracks lock over consecutive good frames.
module vga_sync_decoder #(
  parameter int unsigned TOTAL_COLS       = 800,
  parameter int unsigned TOTAL_ROWS       = 525,
  parameter int unsigned ACTIVE_COLS      = 640,
  parameter int unsigned ACTIVE_ROWS      = 480,
  parameter int unsigned H_ACTIVE_START   = 144,
  parameter int unsigned V_ACTIVE_START   = 35,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
  parameter int unsigned LOCK_FRAMES      = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  vga_sync_decoder_if.slave  bus
);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] H_LO     = 10'(H_ACTIVE_START);
  localparam logic [9:0] H_HI     = 10'(H_ACTIVE_START + ACTIVE_COLS);
  localparam logic [9:0] V_LO     = 10'(V_ACTIVE_START);
  localparam logic [9:0] V_HI     = 10'(V_ACTIVE_START + ACTIVE_ROWS);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic       SYNC_OFF = ~SYNC_ACTIVE_HIGH;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} lock_state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] x);
    return (x == 10'h3FF) ? x : x + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic        h_p0, h_p1, v_p0, v_p1;
  logic        h_edge, v_edge, frame_start;
  logic        line_viol, frame_viol, viol;
  logic [9:0]  col_p2, row_p2;
  logic        arm_p2, fs_p2;
  lock_state_t state_p2, state_d;
  logic [3:0]  good_p2, good_d;
  logic [7:0]  err_p2, err_d;
  logic        locked;

  // Stage 0/1: input capture and previous-value history, parked deasserted in reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_p0 <= SYNC_OFF;
      h_p1 <= SYNC_OFF;
      v_p0 <= SYNC_OFF;
      v_p1 <= SYNC_OFF;
    end else begin
      h_p0 <= bus.i_hsync;
      h_p1 <= h_p0;
      v_p0 <= bus.i_vsync;
      v_p1 <= v_p0;
    end
  end

  assign h_edge      = (h_p0 == SYNC_ACTIVE_HIGH) && (h_p1 != SYNC_ACTIVE_HIGH);
  assign v_edge      = (v_p0 == SYNC_ACTIVE_HIGH) && (v_p1 != SYNC_ACTIVE_HIGH);
  assign frame_start = h_edge && (arm_p2 || v_edge);

  // A missing hsync is flagged on the cycle the column would reach TOTAL_COLS.
  assign line_viol  = h_edge ? (col_p2 != COL_LAST) : (col_p2 == COL_LAST);
  assign frame_viol = frame_start ? (row_p2 != ROW_LAST)
                                  : (h_edge && (row_p2 == ROW_LAST));
  assign viol       = line_viol || frame_viol;

  // Stage 2: position counters, vertical arming and lock state
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      col_p2   <= '0;
      row_p2   <= '0;
      arm_p2   <= 1'b0;
      fs_p2    <= 1'b0;
      state_p2 <= SEARCH;
      good_p2  <= '0;
      err_p2   <= '0;
    end else begin
      col_p2   <= h_edge ? 10'd0 : sat_inc10(col_p2);
      if (frame_start)
        row_p2 <= 10'd0;
      else if (h_edge)
        row_p2 <= sat_inc10(row_p2);
      if (frame_start)
        arm_p2 <= 1'b0;
      else if (v_edge)
        arm_p2 <= 1'b1;
      fs_p2    <= frame_start;
      state_p2 <= state_d;
      good_p2  <= good_d;
      err_p2   <= err_d;
    end
  end

  always_comb begin
    state_d = state_p2;
    good_d  = good_p2;
    err_d   = err_p2;
    case (state_p2)
      SEARCH: begin
        if (frame_start) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (viol) begin
          state_d = SEARCH;
        end else if (frame_start) begin
          good_d = good_p2 + 4'd1;
          if (good_p2 + 4'd1 == LOCK_N)
            state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) begin
          err_d   = sat_inc8(err_p2);
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign locked            = (state_p2 == LOCKED);
  assign bus.o_hsync       = h_p1;
  assign bus.o_vsync       = v_p1;
  assign bus.o_col         = col_p2;
  assign bus.o_row         = row_p2;
  assign bus.o_frame_start = fs_p2;
  assign bus.o_locked      = locked;
  assign bus.o_err_count   = err_p2;
  assign bus.o_active      = locked && (col_p2 >= H_LO) && (col_p2 < H_HI) &&
                             (row_p2 >= V_LO) && (row_p2 < V_HI);

endmodule
